// File: rtl/imem_load_arbiter.sv
// Single-port instruction memory arbiter: CPU fetch passes through in RUN, a
// valid/ready loader stream owns the port in LOAD, then the CPU restarts at 0.
module imem_load_arbiter #(
  parameter int COL   = 16,
  parameter int ROW_I = 16,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      pc,
  output logic [COL-1:0]   instruction,
  output logic             cpu_stall,
  output logic             cpu_restart,
  input  logic             ld_start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [15:0]      ld_addr,
  input  logic [COL-1:0]   ld_data,
  input  logic             ld_last,
  output logic             ld_busy,
  output logic             ld_err,
  output logic [ABITS:0]   ld_count,
  output logic [ABITS-1:0] mem_addr,
  output logic             mem_we,
  output logic [COL-1:0]   mem_wdata,
  input  logic [COL-1:0]   mem_rdata
);

  typedef enum logic [1:0] {RUN, LOAD, SETTLE} state_t;

  localparam logic [ABITS:0] CNT_MAX = (ABITS+1)'(ROW_I);
  localparam logic [ABITS:0] CNT_ONE = (ABITS+1)'(1);

  state_t         state_q;
  logic           stall_q;
  logic           restart_q;
  logic           busy_q;
  logic           err_q;
  logic [ABITS:0] count_q;

  logic in_range;
  logic in_load;

  // Upper fetch-address bits are dropped: fetches wrap modulo the memory depth.
  logic unused_pc;
  assign unused_pc = ^pc[15:ABITS];

  assign in_range = (ld_addr < 16'(ROW_I));
  assign in_load  = (state_q == LOAD);

  assign ld_ready    = in_load;
  assign mem_addr    = in_load ? ld_addr[ABITS-1:0] : pc[ABITS-1:0];
  assign mem_we      = in_load & ld_valid & in_range;
  assign mem_wdata   = ld_data;
  assign instruction = (state_q == RUN) ? mem_rdata : '0;

  assign cpu_stall   = stall_q;
  assign cpu_restart = restart_q;
  assign ld_busy     = busy_q;
  assign ld_err      = err_q;
  assign ld_count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      stall_q   <= 1'b0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      restart_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (ld_start) begin
            state_q <= LOAD;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            count_q <= '0;
          end
        end
        LOAD: begin
          // Every presented beat is accepted; only in-range ones are written.
          if (ld_valid) begin
            if (in_range) begin
              if (count_q != CNT_MAX) count_q <= count_q + CNT_ONE;
            end else begin
              err_q <= 1'b1;
            end
            if (ld_last) begin
              state_q   <= SETTLE;
              restart_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          state_q <= RUN;
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Randomized scoreboard bench for imem_load_arbiter with a behavioural memory
// image and load-status model; a monitor checks every memory write against a queue.
module tb_imem_load_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        cpu_stall, cpu_restart;
  logic        ld_start, ld_valid, ld_ready, ld_last, ld_busy, ld_err;
  logic [15:0] ld_addr, ld_data;
  logic [4:0]  ld_count;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  imem_load_arbiter #(.COL(16), .ROW_I(16), .ABITS(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .cpu_stall(cpu_stall), .cpu_restart(cpu_restart), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .ld_busy(ld_busy), .ld_err(ld_err), .ld_count(ld_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  logic [15:0] ref_mem [16];
  logic        tb_init;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [19:0] wq[$];
  int          exp_count;
  bit          exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write (t=%0t)",
                 mem_addr, mem_wdata, $time);
      end else begin
        logic [19:0] e;
        e = wq.pop_front();
        chk("write_addr", {28'd0, mem_addr}, {28'd0, e[19:16]});
        chk("write_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input logic [15:0] p);
    pc = p;
    @(negedge clk);
    chk("run_instr", {16'd0, instruction}, {16'd0, ref_mem[p[3:0]]});
    chk("run_stall", {31'd0, cpu_stall}, 32'd0);
    chk("run_we", {31'd0, mem_we}, 32'd0);
    step();
  endtask

  task automatic readback();
    for (int i = 0; i < 16; i++)
      run_check({12'($urandom_range(0, 4095)), 4'(i)});
  endtask

  task automatic start_load(input bit with_valid);
    ld_start = 1'b1;
    ld_valid = with_valid;
    ld_addr  = 16'($urandom_range(0, 15));
    ld_data  = 16'($urandom);
    ld_last  = 1'($urandom);
    @(negedge clk);
    chk("start_ready", {31'd0, ld_ready}, 32'd0);
    chk("start_we", {31'd0, mem_we}, 32'd0);
    step();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    exp_count = 0;
    exp_err   = 1'b0;
  endtask

  task automatic load_status(input string tag);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd1);
    chk({tag, "_busy"}, {31'd0, ld_busy}, 32'd1);
    chk({tag, "_instr"}, {16'd0, instruction}, 32'd0);
    chk({tag, "_count"}, {27'd0, ld_count}, 32'(exp_count));
    chk({tag, "_err"}, {31'd0, ld_err}, {31'd0, exp_err});
  endtask

  task automatic beat(input logic [15:0] addr, input logic [15:0] data, input bit last,
                      input int gap, input bit start_mid);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    ld_last  = last;
    if (addr < 16) begin
      wq.push_back({addr[3:0], data});
      ref_mem[addr[3:0]] = data;
    end
    @(negedge clk);
    load_status("beat");
    chk("beat_ready", {31'd0, ld_ready}, 32'd1);
    if (addr < 16) exp_count = (exp_count < 16) ? exp_count + 1 : 16;
    else exp_err = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (!last) begin
      for (int i = 0; i < gap; i++) begin
        ld_last  = 1'($urandom);
        ld_addr  = 16'($urandom);
        ld_start = start_mid && (i == 0);
        @(negedge clk);
        load_status("gap");
        chk("gap_ready", {31'd0, ld_ready}, 32'd1);
        step();
        ld_start = 1'b0;
        ld_last  = 1'b0;
      end
    end else begin
      ld_valid = 1'b1;
      ld_addr  = 16'($urandom_range(0, 15));
      ld_data  = 16'($urandom);
      @(negedge clk);
      load_status("settle");
      chk("settle_restart", {31'd0, cpu_restart}, 32'd1);
      chk("settle_ready", {31'd0, ld_ready}, 32'd0);
      chk("settle_we", {31'd0, mem_we}, 32'd0);
      step();
      ld_valid = 1'b0;
      pc = 16'd0;
      @(negedge clk);
      chk("post_stall", {31'd0, cpu_stall}, 32'd0);
      chk("post_restart", {31'd0, cpu_restart}, 32'd0);
      chk("post_busy", {31'd0, ld_busy}, 32'd0);
      chk("post_count", {27'd0, ld_count}, 32'(exp_count));
      chk("post_err", {31'd0, ld_err}, {31'd0, exp_err});
      chk("post_instr", {16'd0, instruction}, {16'd0, ref_mem[0]});
      step();
    end
  endtask

  initial begin
    reset = 1'b1; tb_init = 1'b1;
    pc = '0; ld_start = 0; ld_valid = 0; ld_last = 0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'($urandom);
    exp_count = 0; exp_err = 1'b0;
    step(); step();
    tb_init = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_restart", {31'd0, cpu_restart}, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_err", {31'd0, ld_err}, 32'd0);
    chk("rst_count", {27'd0, ld_count}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    step();
    reset = 1'b0;

    // Fetch pass-through with wrap
    for (int i = 0; i <= 20; i++) run_check(16'(i));

    // Full sequential load
    start_load(1'b0);
    for (int i = 0; i < 16; i++) beat(16'hA000 & 16'h000F | 16'(i), 16'hA000 + 16'(i), i == 15, 0, 1'b0);
    readback();

    // Gapped load with ignored ld_start in LOAD and an ignored start+valid beat
    start_load(1'b1);
    for (int i = 0; i < 6; i++) beat(16'(15 - i), 16'($urandom), i == 5, 3, i == 2);
    readback();

    // Out-of-range beats: error sticky through RUN, cleared by next start
    start_load(1'b0);
    beat(16'd3, 16'($urandom), 1'b0, 1, 1'b0);
    beat(16'h0020, 16'($urandom), 1'b0, 1, 1'b0);
    beat(16'd16, 16'($urandom), 1'b0, 0, 1'b0);
    beat(16'd15, 16'($urandom), 1'b1, 0, 1'b0);
    // ld_valid in RUN is ignored; error stays set
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 16'(i); ld_data = 16'($urandom); ld_last = 1'($urandom);
      run_check(16'($urandom));
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    chk("err_sticky", {31'd0, ld_err}, 32'd1);
    step();
    start_load(1'b0);
    @(negedge clk);
    chk("err_cleared", {31'd0, ld_err}, 32'd0);
    step();

    // Count saturation: 20 in-range writes in one load
    for (int i = 0; i < 20; i++) beat(16'(i % 16), 16'($urandom), i == 19, 0, 1'b0);
    readback();

    // Reset mid-load
    start_load(1'b0);
    for (int i = 0; i < 5; i++) beat(16'(i), 16'($urandom), 1'b0, 0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 0; exp_err = 1'b0;
    @(negedge clk);
    chk("rst2_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst2_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst2_count", {27'd0, ld_count}, 32'd0);
    chk("rst2_ready", {31'd0, ld_ready}, 32'd0);
    step();
    readback();

    // Random loads
    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 20);
      start_load(1'($urandom));
      for (int i = 0; i < len; i++) begin
        logic [15:0] a;
        a = ($urandom_range(0, 5) == 0) ? 16'(16 + $urandom_range(0, 200))
                                        : 16'($urandom_range(0, 15));
        beat(a, 16'($urandom), i == len - 1, $urandom_range(0, 2), 1'($urandom));
      end
      readback();
    end

    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
